// File: rtl/stack_alu_pkg.sv
`default_nettype none
// ============================================================================
// stack_alu_pkg : shared constants, opcodes, FSM encoding and ALU result type
// Revision 1.0 - initial release
// ============================================================================
package stack_alu_pkg;

    localparam int DATA_W        = 32;
    localparam int TIMEOUT_LIMIT = 16;
    localparam int WAIT_W        = 4;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_LIMIT - 1);

    typedef enum logic [2:0] {
        OP_PUSHI = 3'b000,
        OP_ADD   = 3'b001,
        OP_SUB   = 3'b010,
        OP_AND   = 3'b011,
        OP_OR    = 3'b100,
        OP_XOR   = 3'b101,
        OP_MUL   = 3'b110,
        OP_DROP  = 3'b111
    } opcode_e;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_POP_B = 3'd1;
    localparam logic [2:0] ST_POP_A = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_PUSH  = 3'd4;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              carry;
        logic              zero;
    } alu_out_t;

endpackage
`default_nettype wire

// File: rtl/stack_alu_exec_if.sv
`default_nettype none
// ============================================================================
// stack_alu_exec_if : instruction, stack-pop, stack-push and status signals
// Revision 1.0 - initial release
// ============================================================================
interface stack_alu_exec_if;
    import stack_alu_pkg::*;

    logic              op_stb;
    logic [2:0]        op_code;
    logic [DATA_W-1:0] op_imm;
    logic              op_ack;

    logic              s_pop_stb;
    logic [DATA_W-1:0] s_pop_dat;
    logic              s_pop_ack;

    logic              s_push_stb;
    logic [DATA_W-1:0] s_push_dat;
    logic              s_push_ack;

    logic [DATA_W-1:0] res_dat;
    logic              res_vld;
    logic              flag_z;
    logic              flag_c;
    logic              op_done;
    logic              op_err;
    logic              busy;

    // Issuer and stack side
    modport master (
        output op_stb, op_code, op_imm, s_pop_stb, s_pop_dat, s_push_ack,
        input  op_ack, s_pop_ack, s_push_stb, s_push_dat,
               res_dat, res_vld, flag_z, flag_c, op_done, op_err, busy
    );

    // Execution unit side
    modport slave (
        input  op_stb, op_code, op_imm, s_pop_stb, s_pop_dat, s_push_ack,
        output op_ack, s_pop_ack, s_push_stb, s_push_dat,
               res_dat, res_vld, flag_z, flag_c, op_done, op_err, busy
    );

endinterface
`default_nettype wire

// File: rtl/stack_alu_core.sv
`default_nettype none
// ============================================================================
// stack_alu_core : combinational A op B with carry/borrow and zero flags
// Config macro STACK_ALU_MUL_EN enables the 32x32 multiplier.  Revision 1.0
// ============================================================================
module stack_alu_core
    import stack_alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  opcode_e           opcode,
    output alu_out_t          alu
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        alu.res   = b;
        alu.carry = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu.res   = sum[DATA_W-1:0];
                alu.carry = sum[DATA_W];
            end
            OP_SUB: begin
                alu.res   = a - b;
                alu.carry = (a < b);
            end
            OP_AND: alu.res = a & b;
            OP_OR:  alu.res = a | b;
            OP_XOR: alu.res = a ^ b;
`ifdef STACK_ALU_MUL_EN
            OP_MUL: alu.res = a * b;
`endif
            default: alu.res = b;
        endcase
        alu.zero = (alu.res == '0);
    end

endmodule
`default_nettype wire

// File: rtl/stack_alu_exec.sv
`default_nettype none
// ============================================================================
// stack_alu_exec : stack-machine execution unit (pop operands, execute, push)
// Config macro STACK_ALU_MUL_EN enables opcode MUL.  Revision 1.0
// ============================================================================
module stack_alu_exec
    import stack_alu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    stack_alu_exec_if.slave        bus
);

    logic [2:0]        state;
    logic [WAIT_W-1:0] wait_cnt;
    opcode_e           opcode;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] push_dat;
    logic [DATA_W-1:0] res_dat;
    logic              res_vld;
    logic              flag_z;
    logic              flag_c;
    logic              op_done;
    logic              op_err;
    logic              pop_state;
    logic              stall_expired;
    alu_out_t          alu;

    stack_alu_core u_core (
        .a      (opa),
        .b      (opb),
        .opcode (opcode),
        .alu    (alu)
    );

    assign pop_state     = (state == ST_POP_B) || (state == ST_POP_A);
    assign stall_expired = (wait_cnt == WAIT_LAST);

    // op_ack is gated by rst_n so no strobe can escape while reset is held
    assign bus.op_ack     = rst_n & bus.op_stb & (state == ST_IDLE);
    assign bus.s_pop_ack  = pop_state & bus.s_pop_stb;
    assign bus.s_push_stb = (state == ST_PUSH);
    assign bus.s_push_dat = push_dat;
    assign bus.res_dat    = res_dat;
    assign bus.res_vld    = res_vld;
    assign bus.flag_z     = flag_z;
    assign bus.flag_c     = flag_c;
    assign bus.op_done    = op_done;
    assign bus.op_err     = op_err;
    assign bus.busy       = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            opcode   <= OP_PUSHI;
            opa      <= '0;
            opb      <= '0;
            push_dat <= '0;
            res_dat  <= '0;
            res_vld  <= 1'b0;
            flag_z   <= 1'b1;
            flag_c   <= 1'b0;
            op_done  <= 1'b0;
            op_err   <= 1'b0;
        end else begin
            res_vld <= 1'b0;
            op_done <= 1'b0;
            op_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.op_stb) begin
                        opcode   <= opcode_e'(bus.op_code);
                        wait_cnt <= '0;
                        case (opcode_e'(bus.op_code))
                            OP_PUSHI: begin
                                push_dat <= bus.op_imm;
                                flag_z   <= (bus.op_imm == '0);
                                flag_c   <= 1'b0;
                                state    <= ST_PUSH;
                            end
`ifndef STACK_ALU_MUL_EN
                            OP_MUL: begin
                                op_err  <= 1'b1;
                                op_done <= 1'b1;
                            end
`endif
                            default: state <= ST_POP_B;
                        endcase
                    end
                end
                ST_POP_B, ST_POP_A: begin
                    if (bus.s_pop_stb) begin
                        wait_cnt <= '0;
                        if (state == ST_POP_B) begin
                            opb <= bus.s_pop_dat;
                            if (opcode == OP_DROP) begin
                                state   <= ST_IDLE;
                                op_done <= 1'b1;
                            end else begin
                                state <= ST_POP_A;
                            end
                        end else begin
                            opa   <= bus.s_pop_dat;
                            state <= ST_EXEC;
                        end
                    end else if (stall_expired) begin
                        // Operands already popped are simply dropped
                        state   <= ST_IDLE;
                        op_err  <= 1'b1;
                        op_done <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_EXEC: begin
                    push_dat <= alu.res;
                    flag_z   <= alu.zero;
                    flag_c   <= alu.carry;
                    wait_cnt <= '0;
                    state    <= ST_PUSH;
                end
                ST_PUSH: begin
                    if (bus.s_push_ack) begin
                        res_dat <= push_dat;
                        res_vld <= 1'b1;
                        op_done <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (stall_expired) begin
                        state   <= ST_IDLE;
                        op_err  <= 1'b1;
                        op_done <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stack_alu_exec.sv
`default_nettype none
// ============================================================================
// tb_stack_alu_exec : directed bench with a queue-based stack model
// Revision 1.0 - initial release
// ============================================================================
module tb_stack_alu_exec;
    import stack_alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    initial forever #5 clk = ~clk;

    stack_alu_exec_if bus();

    stack_alu_exec dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] stk[$];
    logic [31:0] push_log[$];
    bit          pop_en     = 1'b1;
    int          push_delay = 0;
    int          push_wait  = 0;
    int          pushes     = 0;
    int          pops       = 0;
    int          overlap    = 0;
    int          stb_cycles = 0;
    int          unstable   = 0;
    int          vld_cyc    = -1;
    int          done_cyc   = -1;
    int          err_cyc    = -1;
    int          acc_cyc    = 0;
    logic        done_busy  = 1'b0;
    logic        prev_stb   = 1'b0;
    logic [31:0] prev_dat   = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Stack model: drive inputs at negedge, record the handshakes the DUT will act on
    initial forever begin
        @(negedge clk);
        bus.s_pop_stb  = pop_en && (stk.size() > 0);
        bus.s_pop_dat  = 32'h0;
        if (stk.size() > 0) bus.s_pop_dat = stk[$];
        bus.s_push_ack = bus.s_push_stb && (push_wait >= push_delay);
        #1;
        if (rst_n) begin
            if (bus.s_pop_ack) begin
                pops++;
                void'(stk.pop_back());
            end
            if (bus.s_push_stb) begin
                stb_cycles++;
                if (prev_stb && (bus.s_push_dat !== prev_dat)) unstable++;
                if (bus.s_push_ack) begin
                    pushes++;
                    stk.push_back(bus.s_push_dat);
                    push_log.push_back(bus.s_push_dat);
                    push_wait = 0;
                end else begin
                    push_wait++;
                end
            end
            if (bus.s_push_stb && bus.s_pop_ack) overlap++;
            if (bus.res_vld) vld_cyc = cyc;
            if (bus.op_done) begin
                done_cyc  = cyc;
                done_busy = bus.busy;
            end
            if (bus.op_err) err_cyc = cyc;
        end else begin
            push_wait = 0;
        end
        prev_stb = bus.s_push_stb && !bus.s_push_ack;
        prev_dat = bus.s_push_dat;
    end

    task automatic run(input logic [2:0] code, input logic [31:0] imm);
        pushes     = 0;
        pops       = 0;
        stb_cycles = 0;
        unstable   = 0;
        push_log.delete();
        vld_cyc  = -1;
        done_cyc = -1;
        err_cyc  = -1;
        @(negedge clk);
        bus.op_stb  = 1'b1;
        bus.op_code = code;
        bus.op_imm  = imm;
        #2;
        acc_cyc = cyc;
        check("op_ack", 32'(bus.op_ack), 1);
        @(negedge clk);
        bus.op_stb = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (done_cyc >= 0) break;
            @(negedge clk);
        end
        check("done_seen", 32'(done_cyc >= 0), 1);
    endtask

    task automatic seq_add_5_7;
        run(OP_PUSHI, 32'd5);
        check("pushi_lat", vld_cyc - acc_cyc, 2);
        check("pushi_res", bus.res_dat, 5);
        run(OP_PUSHI, 32'd7);
        run(OP_ADD, 32'd0);
        check("add_lat", vld_cyc - acc_cyc, 5);
        check("add_res", bus.res_dat, 12);
        check("add_z", 32'(bus.flag_z), 0);
        check("add_c", 32'(bus.flag_c), 0);
        check("add_pops", pops, 2);
        check("add_pushes", pushes, 1);
        check("add_stack_sz", stk.size(), 1);
        if (stk.size() == 1) check("add_stack_top", stk[0], 12);
    endtask

    initial begin
        bus.op_stb  = 1'b1;
        bus.op_code = OP_ADD;
        bus.op_imm  = '0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_op_ack", 32'(bus.op_ack), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_res_dat", bus.res_dat, 0);
        check("rst_flag_z", 32'(bus.flag_z), 1);
        check("rst_flag_c", 32'(bus.flag_c), 0);
        check("rst_res_vld", 32'(bus.res_vld), 0);
        check("rst_op_done", 32'(bus.op_done), 0);
        check("rst_push_stb", 32'(bus.s_push_stb), 0);
        bus.op_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        seq_add_5_7();

        // SUB with borrow, then ADD wrapping to zero
        stk.delete(); stk.push_back(32'd3); stk.push_back(32'd5);
        run(OP_SUB, 0);
        check("sub_res", bus.res_dat, 32'hFFFF_FFFE);
        check("sub_c", 32'(bus.flag_c), 1);
        check("sub_z", 32'(bus.flag_z), 0);
        stk.delete(); stk.push_back(32'hFFFF_FFFF); stk.push_back(32'd1);
        run(OP_ADD, 0);
        check("addc_res", bus.res_dat, 0);
        check("addc_c", 32'(bus.flag_c), 1);
        check("addc_z", 32'(bus.flag_z), 1);
        run(OP_PUSHI, 0);
        check("pushi0_z", 32'(bus.flag_z), 1);
        check("pushi0_c", 32'(bus.flag_c), 0);

        // Bitwise ops
        stk.delete(); stk.push_back(32'hF0F0_00FF); stk.push_back(32'h0FF0_0F0F);
        run(OP_AND, 0);
        check("and_res", bus.res_dat, 32'h00F0_000F);
        stk.delete(); stk.push_back(32'hF0F0_00FF); stk.push_back(32'h0FF0_0F0F);
        run(OP_OR, 0);
        check("or_res", bus.res_dat, 32'hFFF0_0FFF);
        stk.delete(); stk.push_back(32'hF0F0_00FF); stk.push_back(32'h0FF0_0F0F);
        run(OP_XOR, 0);
        check("xor_res", bus.res_dat, 32'hFF00_0FF0);
        check("xor_c", 32'(bus.flag_c), 0);

        // DROP: one pop, no push, results untouched
        stk.push_back(32'h1234_5678);
        run(OP_DROP, 0);
        check("drop_lat", done_cyc - acc_cyc, 2);
        check("drop_pops", pops, 1);
        check("drop_pushes", pushes, 0);
        check("drop_res", bus.res_dat, 32'hFF00_0FF0);
        check("drop_stack_sz", stk.size(), 1);

        // Push acknowledged after 3 stalled cycles
        push_delay = 3;
        run(OP_PUSHI, 32'hA5A5_5A5A);
        push_delay = 0;
        check("slow_stb_cycles", stb_cycles, 4);
        check("slow_unstable", unstable, 0);
        check("slow_pushes", pushes, 1);
        check("slow_lat", vld_cyc - acc_cyc, 5);
        check("slow_res", bus.res_dat, 32'hA5A5_5A5A);

        // Timeout with nothing to pop
        stk.delete();
        run(OP_ADD, 0);
        check("to_done_lat", done_cyc - acc_cyc, 17);
        check("to_err_lat", err_cyc - acc_cyc, 17);
        check("to_pushes", pushes, 0);
        check("to_busy", 32'(done_busy), 0);
        check("to_res", bus.res_dat, 32'hA5A5_5A5A);

        // Timeout after B already popped
        stk.push_back(32'd7);
        run(OP_SUB, 0);
        check("to2_done_lat", done_cyc - acc_cyc, 18);
        check("to2_err_lat", err_cyc - acc_cyc, 18);
        check("to2_pops", pops, 1);
        check("to2_pushes", pushes, 0);

        // MUL
        stk.delete(); stk.push_back(32'h0001_0000); stk.push_back(32'h0001_0001);
        run(OP_MUL, 0);
`ifdef STACK_ALU_MUL_EN
        check("mul_res", bus.res_dat, 32'h0001_0000);
        check("mul_pushes", pushes, 1);
        check("mul_err", 32'(err_cyc >= 0), 0);
`else
        check("mul_err_lat", err_cyc - acc_cyc, 1);
        check("mul_done_lat", done_cyc - acc_cyc, 1);
        check("mul_pops", pops, 0);
        check("mul_pushes", pushes, 0);
        check("mul_res", bus.res_dat, 32'hA5A5_5A5A);
`endif

        // Reset asserted while in EXEC
        stk.delete(); stk.push_back(32'd2); stk.push_back(32'd3);
        @(negedge clk);
        bus.op_stb  = 1'b1;
        bus.op_code = OP_ADD;
        @(negedge clk);
        bus.op_stb = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check("exec_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_res_dat", bus.res_dat, 0);
        check("arst_flag_z", 32'(bus.flag_z), 1);
        check("arst_flag_c", 32'(bus.flag_c), 0);
        check("arst_push_stb", 32'(bus.s_push_stb), 0);
        check("arst_pop_ack", 32'(bus.s_pop_ack), 0);
        @(negedge clk);
        rst_n = 1'b1;
        stk.delete();
        seq_add_5_7();

        check("no_overlap", overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/stack_alu_exec.md
STACK_ALU_EXEC -- requirements
Module: stack_alu_exec

Interface
REQ-001 SHALL have port CLK  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port RST_N  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports OP_STB in 1 (instruction request), OP_CODE in 3 (opcode), OP_IMM in 32 (immediate for PUSHI), OP_ACK out 1 (instruction accepted).
REQ-004 SHALL have ports S_POP_STB in 1 (stack top word valid), S_POP_DAT in 32 (top word), S_POP_ACK out 1 (consume one word).
REQ-005 SHALL have ports S_PUSH_STB out 1 (push request), S_PUSH_DAT out 32 (word to push), S_PUSH_ACK in 1 (push accepted).
REQ-006 SHALL have ports RES_DAT out 32 (last result), RES_VLD out 1, FLAG_Z out 1, FLAG_C out 1, OP_DONE out 1, OP_ERR out 1, BUSY out 1.

Function
REQ-007 SHALL implement FSM states IDLE, POP_B, POP_A, EXEC, PUSH.
REQ-008 SHALL drive OP_ACK = OP_STB when state is IDLE, 0 otherwise; OP_CODE/OP_IMM sampled on the accepting edge.
REQ-009 Opcodes SHALL be: 000 PUSHI, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 MUL, 111 DROP.
REQ-010 On acceptance, PUSHI SHALL go IDLE->PUSH with S_PUSH_DAT=OP_IMM; DROP SHALL go to POP_B and return to IDLE after one pop; binary ops SHALL go POP_B->POP_A->EXEC->PUSH.
REQ-011 In POP_B/POP_A, S_POP_ACK SHALL equal S_POP_STB; word captured (B = top, A = next) on the edge where both high.
REQ-012 EXEC SHALL last exactly one cycle and register result = A op B, truncated to 32 bits; SUB = A-B; MUL = low 32 bits of A*B.
REQ-013 FLAG_C SHALL be carry-out for ADD, borrow (A<B unsigned) for SUB, 0 for other binary ops; FLAG_Z SHALL be (result==0); both updated only in EXEC or PUSHI acceptance (Z from OP_IMM, C=0).
REQ-014 In PUSH, S_PUSH_STB SHALL be 1 with S_PUSH_DAT stable until sampled with S_PUSH_ACK=1, then state SHALL return to IDLE.
REQ-015 S_PUSH_STB and S_POP_ACK SHALL never be high in the same cycle.
REQ-016 RES_VLD SHALL pulse one cycle after a completed push, with RES_DAT holding the pushed word; RES_DAT holds until next push.
REQ-017 OP_DONE SHALL pulse one cycle after any instruction returns to IDLE (success or error).
REQ-018 Minimum latency: binary op RES_VLD 5 cycles after OP_ACK cycle; PUSHI 2 cycles; DROP OP_DONE 2 cycles.
REQ-019 A 4-bit wait counter SHALL clear on entry to POP_B, POP_A, PUSH and increment each cycle the handshake stalls; at 16 stalled cycles state SHALL return to IDLE and OP_ERR SHALL pulse with OP_DONE; already-popped words are discarded.
REQ-020 BUSY SHALL be 1 in every state except IDLE.

Reset
REQ-021 While RST_N=0: state IDLE, counter 0, all strobes/pulses 0, RES_DAT 0, FLAG_Z 1, FLAG_C 0; reset mid-operation aborts without completing any pending push or pop.
REQ-022 Outputs SHALL take reset values immediately on RST_N falling, independent of CLK.

Configuration
REQ-023 Macro STACK_ALU_MUL_EN defined: opcode 110 executes MUL per REQ-012.
REQ-024 Macro STACK_ALU_MUL_EN undefined: opcode 110 accepted, no stack access, OP_ERR and OP_DONE pulse next cycle, flags/RES_DAT unchanged, no multiplier synthesized.

Structure
REQ-025 Package stack_alu_pkg SHALL hold opcode constants, state encoding, data width 32, timeout limit 16.
REQ-026 Combinational sub-module stack_alu_core SHALL compute result, carry and zero from A, B, opcode.

Verification
REQ-027 PUSHI 5, PUSHI 7, ADD, always-ready stack model -> pushes 5, 7, then pops 7, 5, pushes 12; RES_DAT=12, Z=0, C=0, ADD RES_VLD 5 cycles after OP_ACK.
REQ-028 Stack A=3, B=5, SUB -> push 0xFFFFFFFE, C=1, Z=0; A=0xFFFFFFFF, B=1, ADD -> push 0, C=1, Z=1.
REQ-029 Binary op with S_POP_STB held 0 -> after 16 stall cycles OP_ERR=1, OP_DONE=1, no push, BUSY=0 next cycle.
REQ-030 S_PUSH_ACK delayed 3 cycles -> S_PUSH_STB/S_PUSH_DAT stable 4 cycles, single push, no overlapping S_POP_ACK.
REQ-031 MUL A=0x10000, B=0x10001: with STACK_ALU_MUL_EN push 0x00010000; without it OP_ERR pulse, zero stack accesses.
REQ-032 RST_N low during EXEC -> all outputs at reset values before next edge; next ADD after release behaves per REQ-027.
